axi_r_response_allocator: RTL and testbench
===========================================

Name: axi_r_response_allocator

Overview:
- One instance per target (slave-side) port of the AXI node.
- Consumes the per-target rvalid requests from the N_INIT_PORT read back-route decoders.
- Arbitrates among them round-robin, keeping each burst whole until RLAST.
- Strips the routing bits from RID and drives the target port R channel through a one-entry register stage.

Parameters:
N_INIT_PORT, 8, number of initiator-side (memory-side) ports competing for this target port
N_TARG_PORT, 8, number of target ports; sets the routing field width
AXI_ID_IN, 16, RID width at the target port
AXI_ID_OUT, AXI_ID_IN+$clog2(N_TARG_PORT), RID width on the initiator side
AXI_DATA_W, 64, RDATA width
AXI_USER_W, 6, RUSER width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rid_i  in  N_INIT_PORT x AXI_ID_OUT  per-initiator RID
rdata_i  in  N_INIT_PORT x AXI_DATA_W  per-initiator RDATA
rresp_i  in  N_INIT_PORT x 2  per-initiator RRESP
rlast_i  in  N_INIT_PORT  per-initiator RLAST
ruser_i  in  N_INIT_PORT x AXI_USER_W  per-initiator RUSER
rvalid_i  in  N_INIT_PORT  request bit for this target, from each decoder's rvalid_o
rready_o  out  N_INIT_PORT  grant/accept back to each decoder's rready_i
rid_o  out  AXI_ID_IN  RID to target port, lower AXI_ID_IN bits of the granted rid_i
rdata_o  out  AXI_DATA_W  RDATA to target port
rresp_o  out  2  RRESP to target port
rlast_o  out  1  RLAST to target port
ruser_o  out  AXI_USER_W  RUSER to target port
rvalid_o  out  1  R valid to target port
rready_i  in  1  R ready from target port

Behaviour:
- Clocking and reset: single clock `clk`. `rst` is synchronous, active-high.
- Reset state: rvalid_o=0; output register data = 0; rr_ptr=0; lock=0; locked_idx=0; rready_o=0. Reset mid-burst drops the held beat and clears the lock.
- Output stage: one-entry register; out_free = !rvalid_o | rready_i.
- Fall-through latency: 1 cycle from input handshake to rvalid_o.
- Throughput: 1 beat/cycle when rready_i is held high.
- Arbitration when lock=0: grant the first asserted rvalid_i found from index rr_ptr upward, modulo N_INIT_PORT.
- Arbitration when lock=1: the only candidate is locked_idx. Other requests are ignored even if asserted.
- rready_o[g] = out_free & rvalid_i[g] for the granted g only; all other rready_o bits are 0. Purely combinational from current state and inputs.
- On an accepted beat (rvalid_i[g] & rready_o[g]):
  - Register rid_i[g][AXI_ID_IN-1:0] and data/resp/user/last; set rvalid_o=1.
  - If rlast_i[g]=0: lock=1, locked_idx=g.
  - If rlast_i[g]=1: lock=0, rr_ptr=(g+1) mod N_INIT_PORT.
- rr_ptr changes only on an RLAST beat, so single-beat responses rotate fairly.
- If rvalid_o & rready_i and no new beat is accepted, rvalid_o goes to 0 the next cycle.
- Simultaneous output drain and new accept in the same cycle: register loads the new beat; rvalid_o stays 1.
- While rvalid_o=1 and rready_i=0: all outputs hold stable (AXI rule); no rready_o is asserted.
- Locked initiator deasserts rvalid_i mid-burst: lock holds and the allocator waits; no other initiator is served.
- No requests: state unchanged.
- Routing bits rid_i[AXI_ID_OUT-1:AXI_ID_IN] are discarded.
- N_INIT_PORT=1: degenerates to a register slice. rr_ptr and locked_idx are held at 0.
- rr_ptr and locked_idx are $clog2(N_INIT_PORT) wide, minimum 1. Wrap from N_INIT_PORT-1 to 0 is explicit (no reliance on power-of-two width overflow).

Test Plan:
- Reset: hold rst=1 for 3 cycles with rvalid_i=8'hFF -> rvalid_o=0 and rready_o=0 throughout; after release, first grant goes to index 0.
- Round-robin: rvalid_i=8'b0000_1010, single beats (rlast=1), rready_i=1 -> grants 1,3,1,3 on consecutive cycles; rid_o equals low 16 bits of each rid_i; rvalid_o follows 1 cycle behind each grant.
- Burst lock: initiator 2 sends a 4-beat burst, initiator 5 requests throughout -> beats 2,2,2,2 then 5; no interleave; rdata_o sequence matches initiator 2's data in order.
- Backpressure: rready_i=0 for 5 cycles with beat held -> rdata_o/rid_o/rlast_o stable, all rready_o=0; on rready_i=1, next beat accepted the same cycle (no bubble).
- Gap in burst: locked initiator 4 drops rvalid_i for 3 cycles mid-burst while 0 requests -> 0 is not granted until 4's RLAST beat completes.
- Reset mid-burst: assert rst after beat 2 of 4 -> rvalid_o=0 next cycle, lock cleared, rr_ptr=0; fresh request from 6 is granted after release.

Source files
------------

// File: rtl/axi_r_response_allocator.sv
// R-channel allocator for one target port: round-robin arbitration among initiator-side
// read responses with burst locking until RLAST, routing-bit stripping and a one-entry output register.
module axi_r_response_allocator #(
  parameter int N_INIT_PORT = 8,
  parameter int N_TARG_PORT = 8,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] rid_i,
  input  logic [N_INIT_PORT*AXI_DATA_W-1:0] rdata_i,
  input  logic [N_INIT_PORT*2-1:0]          rresp_i,
  input  logic [N_INIT_PORT-1:0]            rlast_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] ruser_i,
  input  logic [N_INIT_PORT-1:0]            rvalid_i,
  output logic [N_INIT_PORT-1:0]            rready_o,
  output logic [AXI_ID_IN-1:0]              rid_o,
  output logic [AXI_DATA_W-1:0]             rdata_o,
  output logic [1:0]                        rresp_o,
  output logic                              rlast_o,
  output logic [AXI_USER_W-1:0]             ruser_o,
  output logic                              rvalid_o,
  input  logic                              rready_i
);

  localparam int IDX_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INIT_PORT - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_INIT_PORT);

  logic                   rvalid_q, rvalid_d;
  logic [AXI_ID_IN-1:0]   rid_q, rid_d;
  logic [AXI_DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic                   rlast_q, rlast_d;
  logic [AXI_USER_W-1:0]  ruser_q, ruser_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   lock_q, lock_d;
  logic [IDX_W-1:0]       locked_idx_q, locked_idx_d;

  logic                   out_free;
  logic                   gnt_valid;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   accept;
  logic [IDX_W:0]         scan_sum;
  logic [IDX_W:0]         scan_wrap;
  logic [IDX_W-1:0]       scan_idx;
  logic                   scan_hit;
  int                     gnt_base_id;
  int                     gnt_base_data;
  int                     gnt_base_resp;
  int                     gnt_base_user;

  // Routing bits above AXI_ID_IN are intentionally dropped at this port.
  logic unused_route_bits;
  assign unused_route_bits = ^rid_i;

  // Grant selection: locked initiator only, else first requester at or after rr_ptr.
  // The scan runs from the farthest offset down so the nearest hit is written last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    scan_wrap = '0;
    scan_idx  = '0;
    scan_hit  = 1'b0;
    if (lock_q) begin
      gnt_idx   = locked_idx_q;
      gnt_valid = rvalid_i[locked_idx_q];
    end else begin
      for (int i = N_INIT_PORT - 1; i >= 0; i--) begin
        scan_sum  = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
        scan_wrap = (scan_sum >= N_EXT) ? (scan_sum - N_EXT) : scan_sum;
        scan_idx  = scan_wrap[IDX_W-1:0];
        scan_hit  = rvalid_i[scan_idx];
        gnt_idx   = scan_hit ? scan_idx : gnt_idx;
        gnt_valid = gnt_valid | scan_hit;
      end
    end
  end

  // Handshake back to the decoders: only the granted bit, only when the register can take a beat.
  always_comb begin
    out_free = ~rvalid_q | rready_i;
    accept   = ~rst & out_free & gnt_valid;
    rready_o = '0;
    rready_o[gnt_idx] = accept;
  end

  // Next-state for the output register, round-robin pointer and burst lock.
  always_comb begin
    gnt_base_id   = int'(gnt_idx) * AXI_ID_OUT;
    gnt_base_data = int'(gnt_idx) * AXI_DATA_W;
    gnt_base_resp = int'(gnt_idx) * 2;
    gnt_base_user = int'(gnt_idx) * AXI_USER_W;
    rvalid_d      = rvalid_q;
    rid_d         = rid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    rlast_d       = rlast_q;
    ruser_d       = ruser_q;
    rr_ptr_d      = rr_ptr_q;
    lock_d        = lock_q;
    locked_idx_d  = locked_idx_q;
    if (accept) begin
      rvalid_d = 1'b1;
      rid_d    = rid_i[gnt_base_id +: AXI_ID_IN];
      rdata_d  = rdata_i[gnt_base_data +: AXI_DATA_W];
      rresp_d  = rresp_i[gnt_base_resp +: 2];
      rlast_d  = rlast_i[gnt_idx];
      ruser_d  = ruser_i[gnt_base_user +: AXI_USER_W];
      if (rlast_i[gnt_idx]) begin
        lock_d   = 1'b0;
        rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : (gnt_idx + 1'b1);
      end else begin
        lock_d       = 1'b1;
        locked_idx_d = gnt_idx;
      end
    end else if (rvalid_q & rready_i) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q     <= 1'b0;
      rid_q        <= '0;
      rdata_q      <= '0;
      rresp_q      <= 2'b00;
      rlast_q      <= 1'b0;
      ruser_q      <= '0;
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
    end else begin
      rvalid_q     <= rvalid_d;
      rid_q        <= rid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rlast_q      <= rlast_d;
      ruser_q      <= ruser_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rid_o    = rid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;
  assign rlast_o  = rlast_q;
  assign ruser_o  = ruser_q;

endmodule

// File: tb/tb_axi_r_response_allocator.sv
// Randomized bench for axi_r_response_allocator: AXI-like burst sources per initiator and a
// transaction-level reference model of arbitration order and the output register.
module tb_axi_r_response_allocator;

  localparam int N   = 8;
  localparam int IDI = 16;
  localparam int IDO = 19;
  localparam int DW  = 64;
  localparam int UW  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*IDO-1:0]  rid_i;
  logic [N*DW-1:0]   rdata_i;
  logic [N*2-1:0]    rresp_i;
  logic [N-1:0]      rlast_i;
  logic [N*UW-1:0]   ruser_i;
  logic [N-1:0]      rvalid_i;
  logic [N-1:0]      rready_o;
  logic [IDI-1:0]    rid_o;
  logic [DW-1:0]     rdata_o;
  logic [1:0]        rresp_o;
  logic              rlast_o;
  logic [UW-1:0]     ruser_o;
  logic              rvalid_o;
  logic              rready_i;

  always #5 clk = ~clk;

  axi_r_response_allocator #(
    .N_INIT_PORT(N), .N_TARG_PORT(8), .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO),
    .AXI_DATA_W(DW), .AXI_USER_W(UW)
  ) dut (
    .clk(clk), .rst(rst), .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .ruser_i(ruser_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .ruser_o(ruser_o), .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  // Source state: each initiator presents one beat at a time and holds it until accepted.
  logic           pres   [N];
  logic [IDO-1:0] s_id   [N];
  logic [DW-1:0]  s_data [N];
  logic [1:0]     s_resp [N];
  logic [UW-1:0]  s_user [N];
  int             s_left [N];

  // Reference model: arbitration memory and the single output slot.
  int             m_rr;
  bit             m_lock;
  int             m_holder;
  bit             m_ov;
  logic [IDI-1:0] m_id;
  logic [DW-1:0]  m_data;
  logic [1:0]     m_resp;
  bit             m_last;
  logic [UW-1:0]  m_user;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_lock = 1'b0; m_holder = 0; m_ov = 1'b0;
    m_id = '0; m_data = '0; m_resp = 2'b00; m_last = 1'b0; m_user = '0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      rvalid_i[i]             = pres[i];
      rid_i[i*IDO +: IDO]     = s_id[i];
      rdata_i[i*DW +: DW]     = s_data[i];
      rresp_i[i*2 +: 2]       = s_resp[i];
      ruser_i[i*UW +: UW]     = s_user[i];
      rlast_i[i]              = (s_left[i] == 1);
    end
  endtask

  task automatic run_cycle(input logic [7:0] mask, input int max_len, input int p_pres,
                           input int p_rdy, input bit rst_v);
    int  g;
    bit  free;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    cycle_no++;
    rst      = rst_v;
    rready_i = ($urandom_range(99) < p_rdy);
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && (mask[i] || s_left[i] > 0) && ($urandom_range(99) < p_pres)) begin
        if (s_left[i] == 0) s_left[i] = $urandom_range(max_len, 1);
        pres[i]   = 1'b1;
        s_id[i]   = IDO'($urandom);
        s_data[i] = {$urandom, $urandom};
        s_resp[i] = 2'($urandom);
        s_user[i] = UW'($urandom);
      end
    end
    drive_inputs();
    #1;
    g    = -1;
    free = !m_ov || rready_i;
    if (!rst_v && free) begin
      if (m_lock) begin
        if (pres[m_holder]) g = m_holder;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && pres[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("rready_o", 64'(rready_o), 64'(exp_rdy));
    @(posedge clk);
    if (rst_v) begin
      model_reset();
    end else if (g >= 0) begin
      m_ov   = 1'b1;
      m_id   = s_id[g][IDI-1:0];
      m_data = s_data[g];
      m_resp = s_resp[g];
      m_user = s_user[g];
      m_last = (s_left[g] == 1);
      if (m_last) begin
        m_lock = 1'b0;
        m_rr   = (g + 1) % N;
      end else begin
        m_lock   = 1'b1;
        m_holder = g;
      end
      s_left[g]--;
      pres[g] = 1'b0;
    end else if (m_ov && rready_i) begin
      m_ov = 1'b0;
    end
    #1;
    check_eq("rvalid_o", 64'(rvalid_o), 64'(m_ov));
    check_eq("rid_o",    64'(rid_o),    64'(m_id));
    check_eq("rdata_o",  64'(rdata_o),  64'(m_data));
    check_eq("rresp_o",  64'(rresp_o),  64'(m_resp));
    check_eq("rlast_o",  64'(rlast_o),  64'(m_last));
    check_eq("ruser_o",  64'(ruser_o),  64'(m_user));
  endtask

  task automatic run_n(input int n, input logic [7:0] mask, input int max_len,
                       input int p_pres, input int p_rdy);
    for (int c = 0; c < n; c++) run_cycle(mask, max_len, p_pres, p_rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    rready_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      pres[i] = 1'b0; s_id[i] = '0; s_data[i] = '0; s_resp[i] = 2'b00;
      s_user[i] = '0; s_left[i] = 0;
    end
    drive_inputs();
    model_reset();

    // Reset held with every initiator requesting; first grant afterwards is index 0.
    for (int c = 0; c < 3; c++) run_cycle(8'hFF, 1, 100, 100, 1'b1);
    run_n(10, 8'hFF, 1, 100, 100);
    // Single-beat round robin between initiators 1 and 3.
    run_n(12, 8'b0000_1010, 1, 100, 100);
    // Bursts from 2 and 5 competing, no interleave inside a burst.
    run_n(24, 8'b0010_0100, 4, 100, 100);
    // Heavy backpressure on the target port.
    run_n(40, 8'hFF, 4, 80, 20);
    // Gaps inside bursts of 4 while 0 keeps asking.
    run_n(40, 8'b0001_0001, 4, 30, 90);
    // Reset in the middle of bursts, then a fresh request from 6.
    run_n(5, 8'hFF, 4, 100, 100);
    run_cycle(8'hFF, 4, 100, 100, 1'b1);
    run_n(12, 8'b0100_0000, 4, 100, 100);
    // Long random mix with occasional resets.
    for (int c = 0; c < 2000; c++)
      run_cycle(8'($urandom), 4, $urandom_range(100, 20), 70, ($urandom_range(299) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
